// File: rtl/bitonic_sort.sv
// 8-lane bitonic sorting network: six compare-exchange layers, each layer
// registered, so a sorted set appears five edges after the edge that samples it.
module bitonic_sort #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   input  logic [WIDTH-1:0] in4,
   input  logic [WIDTH-1:0] in5,
   input  logic [WIDTH-1:0] in6,
   input  logic [WIDTH-1:0] in7,
   input  logic [WIDTH-1:0] in8,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out5,
   output logic [WIDTH-1:0] out6,
   output logic [WIDTH-1:0] out7,
   output logic [WIDTH-1:0] out8
);

   typedef logic [7:0][WIDTH-1:0] lanes_t;

   // Ascending puts the min on lane i; descending puts the max on lane i.
   function automatic lanes_t cx(input lanes_t v, input logic [2:0] i, input logic [2:0] j,
                                 input logic asc);
      lanes_t r;
      logic   swap;
      r    = v;
      swap = asc ? (v[i] > v[j]) : (v[i] < v[j]);
      if (swap) begin
         r[i] = v[j];
         r[j] = v[i];
      end
      return r;
   endfunction

   lanes_t in_v;
   lanes_t l1_d, l2_d, l3_d, l4_d, l5_d, l6_d;
   lanes_t l1_q, l2_q, l3_q, l4_q, l5_q, l6_q;

   assign in_v = {in8, in7, in6, in5, in4, in3, in2, in1};

   // Layers 1-3 build two bitonic halves (lower ascending, upper descending).
   always_comb begin
      l1_d = in_v;
      l1_d = cx(l1_d, 3'd0, 3'd1, 1'b1);
      l1_d = cx(l1_d, 3'd2, 3'd3, 1'b0);
      l1_d = cx(l1_d, 3'd4, 3'd5, 1'b1);
      l1_d = cx(l1_d, 3'd6, 3'd7, 1'b0);
   end

   always_comb begin
      l2_d = l1_q;
      l2_d = cx(l2_d, 3'd0, 3'd2, 1'b1);
      l2_d = cx(l2_d, 3'd1, 3'd3, 1'b1);
      l2_d = cx(l2_d, 3'd4, 3'd6, 1'b0);
      l2_d = cx(l2_d, 3'd5, 3'd7, 1'b0);
   end

   always_comb begin
      l3_d = l2_q;
      l3_d = cx(l3_d, 3'd0, 3'd1, 1'b1);
      l3_d = cx(l3_d, 3'd2, 3'd3, 1'b1);
      l3_d = cx(l3_d, 3'd4, 3'd5, 1'b0);
      l3_d = cx(l3_d, 3'd6, 3'd7, 1'b0);
   end

   // Layers 4-6 merge the 8-wide bitonic sequence into ascending order.
   always_comb begin
      l4_d = l3_q;
      l4_d = cx(l4_d, 3'd0, 3'd4, 1'b1);
      l4_d = cx(l4_d, 3'd1, 3'd5, 1'b1);
      l4_d = cx(l4_d, 3'd2, 3'd6, 1'b1);
      l4_d = cx(l4_d, 3'd3, 3'd7, 1'b1);
   end

   always_comb begin
      l5_d = l4_q;
      l5_d = cx(l5_d, 3'd0, 3'd2, 1'b1);
      l5_d = cx(l5_d, 3'd1, 3'd3, 1'b1);
      l5_d = cx(l5_d, 3'd4, 3'd6, 1'b1);
      l5_d = cx(l5_d, 3'd5, 3'd7, 1'b1);
   end

   always_comb begin
      l6_d = l5_q;
      l6_d = cx(l6_d, 3'd0, 3'd1, 1'b1);
      l6_d = cx(l6_d, 3'd2, 3'd3, 1'b1);
      l6_d = cx(l6_d, 3'd4, 3'd5, 1'b1);
      l6_d = cx(l6_d, 3'd6, 3'd7, 1'b1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         l1_q <= '0;
         l2_q <= '0;
         l3_q <= '0;
         l4_q <= '0;
         l5_q <= '0;
         l6_q <= '0;
      end else begin
         l1_q <= l1_d;
         l2_q <= l2_d;
         l3_q <= l3_d;
         l4_q <= l4_d;
         l5_q <= l5_d;
         l6_q <= l6_d;
      end
   end

   assign out1 = l6_q[0];
   assign out2 = l6_q[1];
   assign out3 = l6_q[2];
   assign out4 = l6_q[3];
   assign out5 = l6_q[4];
   assign out6 = l6_q[5];
   assign out7 = l6_q[6];
   assign out8 = l6_q[7];

endmodule

// File: tb/tb_bitonic_sort.sv
// Bench for bitonic_sort: directed and random sets against a queue-sort reference,
// with reset tracking so in-flight sets discarded by reset are expected as zero.
module tb_bitonic_sort;

   localparam int unsigned WIDTH = 8;
   localparam int Lat = 5;
   localparam int MaxCyc = 16384;

   typedef logic [7:0][WIDTH-1:0] set_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] in1, in2, in3, in4, in5, in6, in7, in8;
   logic [WIDTH-1:0] out1, out2, out3, out4, out5, out6, out7, out8;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_rst = -1;
   set_t sorted_at [MaxCyc];

   bitonic_sort #(.WIDTH(WIDTH)) dut (
      .clk (clk),  .rst (rst),
      .in1 (in1),  .in2 (in2),  .in3 (in3),  .in4 (in4),
      .in5 (in5),  .in6 (in6),  .in7 (in7),  .in8 (in8),
      .out1(out1), .out2(out2), .out3(out3), .out4(out4),
      .out5(out5), .out6(out6), .out7(out7), .out8(out8)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input set_t got, input set_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic set_t ref_sort(input set_t v);
      int   q[$];
      set_t r;
      for (int i = 0; i < 8; i++) q.push_back(int'(v[i]));
      q.sort();
      for (int i = 0; i < 8; i++) r[i] = WIDTH'(q[i]);
      return r;
   endfunction

   function automatic set_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
      set_t r;
      r[0] = WIDTH'(a0); r[1] = WIDTH'(a1); r[2] = WIDTH'(a2); r[3] = WIDTH'(a3);
      r[4] = WIDTH'(a4); r[5] = WIDTH'(a5); r[6] = WIDTH'(a6); r[7] = WIDTH'(a7);
      return r;
   endfunction

   function automatic set_t rand_set();
      set_t r;
      int   mode;
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 8; i++) begin
         if (mode == 0) r[i] = WIDTH'($urandom_range(0, 3));
         else           r[i] = WIDTH'($urandom_range(0, 255));
      end
      return r;
   endfunction

   // Drive one set (and rst) for one edge, then check the outputs after that edge.
   task automatic cycle(input set_t v, input logic r, input string name);
      set_t exp;
      set_t got;
      {in8, in7, in6, in5, in4, in3, in2, in1} = v;
      rst = r;
      sorted_at[cyc] = ref_sort(v);
      @(posedge clk);
      if (r) last_rst = cyc;
      #1;
      if (cyc - Lat >= 0 && last_rst < cyc - Lat) exp = sorted_at[cyc - Lat];
      else exp = '0;
      got = {out8, out7, out6, out5, out4, out3, out2, out1};
      check($sformatf("%s@%0d", name, cyc), got, exp);
      cyc++;
   endtask

   task automatic hold(input set_t v, input int n, input string name);
      for (int i = 0; i < n; i++) cycle(v, 1'b0, name);
   endtask

   initial begin
      set_t s;
      cycle('0, 1'b1, "reset");
      cycle('0, 1'b1, "reset");

      hold(mk(3, 1, 4, 1, 5, 9, 1, 1), 7, "pi");
      check("pi_direct", {out8, out7, out6, out5, out4, out3, out2, out1},
            mk(1, 1, 1, 1, 3, 4, 5, 9));
      hold(mk(8, 7, 6, 5, 4, 3, 2, 1), 6, "reverse");
      check("reverse_direct", {out8, out7, out6, out5, out4, out3, out2, out1},
            mk(1, 2, 3, 4, 5, 6, 7, 8));
      hold(mk(1, 2, 3, 4, 5, 6, 7, 8), 6, "sorted");
      hold(mk(255, 0, 255, 0, 128, 127, 0, 255), 6, "extremes");
      check("extremes_direct", {out8, out7, out6, out5, out4, out3, out2, out1},
            mk(0, 0, 0, 127, 128, 255, 255, 255));
      hold(mk(42, 42, 42, 42, 42, 42, 42, 42), 6, "equal");

      for (int i = 0; i < 8; i++) cycle(rand_set(), 1'b0, "b2b");
      for (int i = 0; i < 3; i++) cycle(rand_set(), 1'b0, "pre_rst");
      cycle(rand_set(), 1'b1, "mid_rst");
      for (int i = 0; i < 8; i++) cycle(rand_set(), 1'b0, "post_rst");

      for (int i = 0; i < 10000; i++) begin
         s = rand_set();
         cycle(s, 1'b0, "rand");
      end
      for (int i = 0; i < 6; i++) cycle(rand_set(), 1'b0, "flush");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
